// File: rtl/ffmode_pipe.sv
// Elastic valid/ready register pipeline of DEPTH bubble-collapsing stages with a
// global clock enable, an enable-gated flush, and occupancy/transfer counters.
module ffmode_pipe #(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int               CNT_W   = 8,
  localparam int              OCC_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy,
  output logic [CNT_W-1:0] xfer_cnt
);

  logic [WIDTH-1:0] data_q   [DEPTH];
  logic [WIDTH-1:0] stage_in [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] move;
  logic [DEPTH-1:0] load;
  logic [OCC_W-1:0] occ_q;
  logic [CNT_W-1:0] xfer_q;
  logic             active;
  logic             in_acc;
  logic             out_hs;
  logic             down_free;

  // Handshakes only exist in a normal-advance cycle; rst, flush and cen=0 all mask them.
  assign active    = cen & ~clr & ~rst;
  assign in_ready  = active & (~vld_q[0] | move[0]);
  assign in_acc    = in_valid & in_ready;
  assign out_valid = active & vld_q[DEPTH-1];
  assign out_hs    = out_valid & out_ready;
  assign out_data  = data_q[DEPTH-1];
  assign occupancy = occ_q;
  assign xfer_cnt  = xfer_q;

  // Ripple the "downstream can take a word" condition from the output back to
  // stage 0 through a scalar so the move vector never feeds itself.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    move      = '0;
    down_free = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      move[i]   = vld_q[i] & down_free;
      down_free = ~vld_q[i] | move[i];
    end
  end

  always_comb begin
    load        = '0;
    stage_in[0] = in_data;
    load[0]     = in_acc;
    for (int i = 1; i < DEPTH; i++) begin
      stage_in[i] = data_q[i-1];
      load[i]     = move[i-1];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every stage samples
    // its neighbour's pre-edge value and the shift behaves as a true pipeline.
    if (rst) begin
      vld_q  <= '0;
      occ_q  <= '0;
      xfer_q <= '0;
      // NOTE: the data array is reset here on purpose; RST_VAL selects set vs
      // reset flops per bit, and only rst/clr may touch stage data.
      for (int i = 0; i < DEPTH; i++) data_q[i] <= RST_VAL;
    end else if (cen) begin
      if (clr) begin
        vld_q <= '0;
        occ_q <= '0;
        for (int i = 0; i < DEPTH; i++) data_q[i] <= RST_VAL;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (load[i]) data_q[i] <= stage_in[i];
        end
        vld_q <= load | (vld_q & ~move);
        case ({in_acc, out_hs})
          2'b10:   occ_q <= occ_q + OCC_W'(1);
          2'b01:   occ_q <= occ_q - OCC_W'(1);
          default: occ_q <= occ_q;
        endcase
        if (out_hs) xfer_q <= xfer_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/ffmode_pipe.md
# ffmode_pipe

Parametrised elastic register pipeline for the iCE40 packer test suite, built to exercise every single-clock DFF flavour (plain, enable, sync reset, sync set, enable-gated sync reset/set) at arbitrary width and depth. A WIDTH-bit word travels through DEPTH bubble-collapsing stages under a valid/ready handshake, with a global clock enable, an enable-gated clear, and occupancy and transfer counters. It sits in the pack test designs as a scalable stimulus block for DFF→SB_DFF* mapping and LC packing.

## Interface
- WIDTH, 8, data width per stage (≥1)
- DEPTH, 4, number of pipeline stages (≥1)
- RST_VAL, {WIDTH{1'b0}}, data register value after rst/clr; 1-bits map to sync-set FFs, 0-bits to sync-reset FFs
- CNT_W, 8, width of transfer counter (≥1)

- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset; not gated by cen
- cen  in  1  global clock enable; 0 freezes all state except rst
- clr  in  1  synchronous flush; acts only when cen=1
- in_valid  in  1  upstream word valid
- in_ready  out  1  block accepts word this cycle
- in_data  in  WIDTH  upstream word
- out_valid  out  1  last stage holds a valid word
- out_ready  in  1  downstream accepts word
- out_data  out  WIDTH  last stage data
- occupancy  out  $clog2(DEPTH+1)  number of valid stages, 0..DEPTH
- xfer_cnt  out  CNT_W  count of completed output handshakes, wraps

## Operation
- State: per stage i (0..DEPTH-1) data[i] (WIDTH) and vld[i]; occupancy register; xfer_cnt register.
- Priority per edge: rst > (cen & clr) > (cen & normal advance) > hold.
- rst=1: all vld=0, all data=RST_VAL, occupancy=0, xfer_cnt=0, regardless of cen.
- cen=1, clr=1: all vld=0, all data=RST_VAL, occupancy=0; xfer_cnt unchanged; no handshake completes (in_ready=0, out_valid=0 this cycle).
- cen=0: no register changes; in_ready=0; out_valid=0 (masked); words in flight retained.
- Normal advance (cen=1, clr=0, rst=0):
  - move[DEPTH-1] = vld[DEPTH-1] & out_ready.
  - move[i] = vld[i] & (~vld[i+1] | move[i+1]) for i<DEPTH-1.
  - Stage i+1 loads data[i] when move[i]; stage 0 loads in_data when in_valid & in_ready.
  - vld[i] next = (incoming into i) | (vld[i] & ~move[i]).
  - in_ready = ~vld[0] | move[0]; combinationally depends on out_ready through the chain.
  - Stages not loading hold data (enable FFs); data of invalid stages is don't-care but must not be reset outside rst/clr.
- occupancy next = occupancy + (in accept) − (out handshake); both in one cycle → unchanged. Never exceeds DEPTH.
- xfer_cnt increments by 1 per out_valid & out_ready; wraps 2^CNT_W−1 → 0.
- out_valid = cen & ~clr & ~rst & vld[DEPTH-1]; out_data = data[DEPTH-1] unconditionally.
- Ordering: words exit in acceptance order; no drop, no duplication.

## Timing
- Reset values (after a rst edge): out_valid 0, out_data RST_VAL, occupancy 0, xfer_cnt 0; in_ready 0 while rst high, 1 on first cycle after rst with cen=1.
- Latency: word accepted at edge t through empty pipe appears on out_* after edge t+DEPTH−1 (DEPTH=1: visible immediately after accept edge).
- Throughput: one word per cycle while out_ready=1 and cen=1.
- Full pipe (occupancy=DEPTH), out_ready=0: in_ready=0; data held stable.
- Full pipe, out_ready=1: simultaneous accept and output in same cycle, occupancy stays DEPTH.
- Bubbles collapse: a stalled output with gaps upstream still fills forward one stage per cycle.
- cen low mid-transfer: state frozen exactly; resumes next cen=1 cycle with no loss.
- clr with cen=0: ignored. rst mid-transfer: all in-flight words discarded.
- No combinational path from in_valid/in_data to outputs other than in_ready (none from in_valid).

## Test plan
- WIDTH=8, DEPTH=4, RST_VAL=8'hA5: assert rst 2 cycles with cen=0 → out_data=8'hA5, out_valid=0, occupancy=0, xfer_cnt=0.
- Stream 0x01..0x08 with out_ready=1, cen=1 → first out_valid 3 cycles after first accept edge, outputs 0x01..0x08 in order, one per cycle, xfer_cnt=8.
- out_ready=0, push 5 words → in_ready drops after 4 accepts, occupancy=4; raise out_ready → words 1..4 then 5 exit, occupancy back to 0.
- Fill 2 words, cen=0 for 3 cycles with clr=1 and out_ready=1 → no change, occupancy=2; cen=1 with clr=0 → both words delivered.
- Fill 3 words, cen=1 clr=1 one cycle → occupancy=0, out_data=RST_VAL, xfer_cnt unchanged; rst mid-stream likewise clears and zeros xfer_cnt.
- CNT_W=2: complete 5 output handshakes → xfer_cnt reads 1 (wrap verified).
